// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: port widths plus the L2 arbiter
// state and owner encodings.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_mem_data;
   typedef logic [15:0]  lc3b_mem_wmask;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DONE    = 2'd3
   } lc3b_arb_state;

   typedef enum logic {
      ARB_I = 1'b0,
      ARB_D = 1'b1
   } lc3b_arb_owner;

endpackage

// File: rtl/l2_arbiter_mux.sv
// Combinational steering of the granted L1's command onto the L2 port and
// of the L2 response back to that L1 only.
module l2_arbiter_mux
   import lc3b_types::*;
(
   input  lc3b_arb_state state_i,
   input  logic          active_i,
   input  logic          i_read_i,
   input  lc3b_word      i_addr_i,
   input  logic          d_read_i,
   input  logic          d_write_i,
   input  lc3b_mem_wmask d_be_i,
   input  lc3b_word      d_addr_i,
   input  lc3b_mem_data  d_wdata_i,
   input  logic          l2_resp_i,
   output logic          l2_read_o,
   output logic          l2_write_o,
   output lc3b_mem_wmask l2_be_o,
   output lc3b_word      l2_addr_o,
   output lc3b_mem_data  l2_wdata_o,
   output logic          i_resp_o,
   output logic          d_resp_o,
   output logic          grant_i_o,
   output logic          grant_d_o
);

   always_comb begin
      l2_read_o  = 1'b0;
      l2_write_o = 1'b0;
      l2_be_o    = '0;
      l2_addr_o  = '0;
      l2_wdata_o = '0;
      i_resp_o   = 1'b0;
      d_resp_o   = 1'b0;
      grant_i_o  = 1'b0;
      grant_d_o  = 1'b0;
      // Grant and resp are qualified by reset so they fall in the reset cycle;
      // the command itself follows the registered state.
      case (state_i)
         SERVE_I: begin
            l2_read_o = i_read_i;
            l2_be_o   = 16'hFFFF;
            l2_addr_o = i_addr_i;
            i_resp_o  = l2_resp_i & active_i;
            grant_i_o = active_i;
         end
         SERVE_D: begin
            l2_read_o  = d_read_i;
            l2_write_o = d_write_i;
            l2_be_o    = d_be_i;
            l2_addr_o  = d_addr_i;
            l2_wdata_o = d_wdata_i;
            d_resp_o   = l2_resp_i & active_i;
            grant_d_o  = active_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates the single l2_cache port between the L1 I-cache and D-cache,
// holding each grant until l2_cache completes the transaction.
module l2_arbiter
   import lc3b_types::*;
#(
   parameter int RR_MODE = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_mem_read,
   input  lc3b_word      i_mem_address,
   output lc3b_mem_data  i_mem_rdata,
   output logic          i_mem_resp,
   input  logic          d_mem_read,
   input  logic          d_mem_write,
   input  lc3b_mem_wmask d_mem_byte_enable,
   input  lc3b_word      d_mem_address,
   input  lc3b_mem_data  d_mem_wdata,
   output lc3b_mem_data  d_mem_rdata,
   output logic          d_mem_resp,
   output logic          l2_mem_read,
   output logic          l2_mem_write,
   output lc3b_mem_wmask l2_mem_byte_enable,
   output lc3b_word      l2_mem_address,
   output lc3b_mem_data  l2_mem_wdata,
   input  lc3b_mem_data  l2_mem_rdata,
   input  logic          l2_mem_resp,
   output logic          grant_i,
   output logic          grant_d
);

   lc3b_arb_state state_q, state_d;
   lc3b_arb_owner last_grant_q, last_grant_d;
   logic          i_req, d_req;

   assign i_req = i_mem_read;
   assign d_req = d_mem_read | d_mem_write;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= ARB_D;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            // On a tie, round-robin favours whoever was not served last.
            if (i_req && (!d_req || (RR_MODE != 0 && last_grant_q == ARB_D))) begin
               state_d      = SERVE_I;
               last_grant_d = ARB_I;
            end else if (d_req) begin
               state_d      = SERVE_D;
               last_grant_d = ARB_D;
            end
         end
         SERVE_I, SERVE_D: begin
            if (l2_mem_resp)
               state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   l2_arbiter_mux u_mux (
      .state_i    (state_q),
      .active_i   (reset_n),
      .i_read_i   (i_mem_read),
      .i_addr_i   (i_mem_address),
      .d_read_i   (d_mem_read),
      .d_write_i  (d_mem_write),
      .d_be_i     (d_mem_byte_enable),
      .d_addr_i   (d_mem_address),
      .d_wdata_i  (d_mem_wdata),
      .l2_resp_i  (l2_mem_resp),
      .l2_read_o  (l2_mem_read),
      .l2_write_o (l2_mem_write),
      .l2_be_o    (l2_mem_byte_enable),
      .l2_addr_o  (l2_mem_address),
      .l2_wdata_o (l2_mem_wdata),
      .i_resp_o   (i_mem_resp),
      .d_resp_o   (d_mem_resp),
      .grant_i_o  (grant_i),
      .grant_d_o  (grant_d)
   );

   assign i_mem_rdata = l2_mem_rdata;
   assign d_mem_rdata = l2_mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: a round-robin instance and a fixed-priority
// instance share all stimulus except their resets.
module tb_l2_arbiter;
   import lc3b_types::*;

   logic          clk = 1'b0;
   logic          rst_n, rst_fp_n;
   logic          i_mem_read, d_mem_read, d_mem_write, l2_mem_resp;
   lc3b_word      i_mem_address, d_mem_address;
   lc3b_mem_wmask d_mem_byte_enable;
   lc3b_mem_data  d_mem_wdata, l2_mem_rdata;

   lc3b_mem_data  i_rdata, d_rdata, l2_wdata;
   logic          i_resp, d_resp, l2_read, l2_write, g_i, g_d;
   lc3b_mem_wmask l2_be;
   lc3b_word      l2_addr;

   lc3b_mem_data  f_i_rdata, f_d_rdata, f_l2_wdata;
   logic          f_i_resp, f_d_resp, f_l2_read, f_l2_write, f_g_i, f_g_d;
   lc3b_mem_wmask f_l2_be;
   lc3b_word      f_l2_addr;

   int chk_cnt = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   l2_arbiter #(.RR_MODE(1)) u_dut (
      .clk(clk), .reset_n(rst_n),
      .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
      .i_mem_rdata(i_rdata), .i_mem_resp(i_resp),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
      .d_mem_byte_enable(d_mem_byte_enable), .d_mem_address(d_mem_address),
      .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_rdata), .d_mem_resp(d_resp),
      .l2_mem_read(l2_read), .l2_mem_write(l2_write),
      .l2_mem_byte_enable(l2_be), .l2_mem_address(l2_addr),
      .l2_mem_wdata(l2_wdata), .l2_mem_rdata(l2_mem_rdata),
      .l2_mem_resp(l2_mem_resp), .grant_i(g_i), .grant_d(g_d)
   );

   l2_arbiter #(.RR_MODE(0)) u_fp (
      .clk(clk), .reset_n(rst_fp_n),
      .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
      .i_mem_rdata(f_i_rdata), .i_mem_resp(f_i_resp),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
      .d_mem_byte_enable(d_mem_byte_enable), .d_mem_address(d_mem_address),
      .d_mem_wdata(d_mem_wdata), .d_mem_rdata(f_d_rdata), .d_mem_resp(f_d_resp),
      .l2_mem_read(f_l2_read), .l2_mem_write(f_l2_write),
      .l2_mem_byte_enable(f_l2_be), .l2_mem_address(f_l2_addr),
      .l2_mem_wdata(f_l2_wdata), .l2_mem_rdata(l2_mem_rdata),
      .l2_mem_resp(l2_mem_resp), .grant_i(f_g_i), .grant_d(f_g_d)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      chk_cnt++;
      if (got === exp) begin
         pass_cnt++;
         $display("ok   %s: %h", tag, got);
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // All stimulus changes and samples happen around the falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic l2_ack(input lc3b_mem_data data);
      l2_mem_resp  = 1'b1;
      l2_mem_rdata = data;
      #1;
   endtask

   task automatic l2_idle();
      l2_mem_resp = 1'b0;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; rst_fp_n = 1'b0;
      i_mem_read = 1'b1; d_mem_read = 1'b0; d_mem_write = 1'b1; l2_mem_resp = 1'b0;
      i_mem_address = 16'h0; d_mem_address = 16'h0; d_mem_byte_enable = 16'h0;
      d_mem_wdata = '0; l2_mem_rdata = '0;

      // Reset held with both requesting
      repeat (2) cyc();
      check("rst_l2_read",  l2_read, 0);
      check("rst_l2_write", l2_write, 0);
      check("rst_resps",    {i_resp, d_resp}, 0);
      check("rst_grants",   {g_i, g_d}, 0);
      check("rst_be",       l2_be, 0);
      rst_n = 1'b1;
      cyc();
      check("rel_l2_read", l2_read, 1);
      check("rel_grants",  {g_i, g_d}, 2'b10);
      l2_ack('0);
      check("rel_i_resp", i_resp, 1);
      i_mem_read = 1'b0; d_mem_write = 1'b0;
      cyc(); l2_idle();
      check("rel_done_grants", {g_i, g_d}, 0);
      cyc();

      // Single I read, L2 answers in the fifth serve cycle
      i_mem_read = 1'b1; i_mem_address = 16'h1230;
      cyc();
      check("ird_addr", l2_addr, 16'h1230);
      check("ird_be",   l2_be, 16'hFFFF);
      check("ird_cmd",  {l2_read, l2_write}, 2'b10);
      check("ird_wdata", l2_wdata, 0);
      repeat (4) begin
         cyc();
         check("ird_wait_resp", {i_resp, d_resp}, 0);
      end
      l2_ack({16{8'hA5}});
      check("ird_resps", {i_resp, d_resp}, 2'b10);
      check("ird_rdata", i_rdata, {16{8'hA5}});
      i_mem_read = 1'b0;
      cyc(); l2_idle();
      check("ird_done", {l2_read, i_resp, g_i}, 0);
      cyc();
      check("ird_idle", {g_i, g_d, l2_read}, 0);

      // D write forwarded unchanged
      d_mem_write = 1'b1; d_mem_address = 16'h4560; d_mem_byte_enable = 16'h00FF;
      d_mem_wdata = 128'h0123456789ABCDEF_FEDCBA9876543210;
      cyc();
      check("dwr_cmd",   {l2_read, l2_write}, 2'b01);
      check("dwr_addr",  l2_addr, 16'h4560);
      check("dwr_be",    l2_be, 16'h00FF);
      check("dwr_wdata", l2_wdata, 128'h0123456789ABCDEF_FEDCBA9876543210);
      check("dwr_grant", {g_i, g_d}, 2'b01);
      cyc();
      check("dwr_pre_resp", d_resp, 0);
      l2_ack(128'h5A);
      check("dwr_resp", {i_resp, d_resp}, 2'b01);
      check("dwr_rdata", d_rdata, 128'h5A);
      d_mem_write = 1'b0;
      cyc(); l2_idle();
      check("dwr_post_resp", d_resp, 0);
      cyc();

      // Simultaneous requests, round-robin: I, D, I, D
      i_mem_read = 1'b1; d_mem_read = 1'b1; d_mem_address = 16'h2220;
      for (int k = 0; k < 4; k++) begin
         cyc();
         check($sformatf("rr_grant%0d", k), {g_i, g_d}, (k % 2 == 0) ? 2'b10 : 2'b01);
         l2_ack('0);
         cyc(); l2_idle();
         if (k == 3) begin
            i_mem_read = 1'b0; d_mem_read = 1'b0;
         end
         cyc();
      end

      // Contention hold: D granted, I waits through a 10-cycle L2 access
      d_mem_write = 1'b1; d_mem_address = 16'h4560;
      cyc();
      check("hold_start", {g_i, g_d, l2_addr}, {2'b01, 16'h4560});
      i_mem_read = 1'b1; i_mem_address = 16'h1230;
      for (int k = 0; k < 9; k++) begin
         cyc();
         check($sformatf("hold_c%0d", k), {g_i, g_d, l2_addr}, {2'b01, 16'h4560});
      end
      l2_ack('0);
      check("hold_d_resp", {i_resp, d_resp}, 2'b01);
      d_mem_write = 1'b0;
      cyc(); l2_idle();
      check("hold_done", {g_i, g_d}, 0);
      cyc();
      check("hold_idle", {g_i, g_d}, 0);
      cyc();
      check("hold_i_grant", {g_i, g_d, l2_addr}, {2'b10, 16'h1230});
      l2_ack('0);
      check("hold_i_resp", i_resp, 1);
      i_mem_read = 1'b0;
      cyc(); l2_idle();
      cyc();

      // Reset while serving D; L2 response lands a cycle later
      d_mem_read = 1'b1; d_mem_address = 16'h7770;
      cyc();
      check("rsd_serve", {g_d, l2_read}, 2'b11);
      rst_n = 1'b0;
      #1;
      check("rsd_grant_drop", g_d, 0);
      cyc();
      l2_ack('0);
      check("rsd_ignored", {d_resp, g_d, l2_read}, 0);
      check("rsd_state", u_dut.state_q, IDLE);
      d_mem_read = 1'b0;
      cyc(); l2_idle();
      rst_n = 1'b1;
      cyc();
      check("rsd_after", {g_i, g_d, l2_read}, 0);

      // Fixed priority instance: D first even when I would win round-robin
      rst_n = 1'b0; rst_fp_n = 1'b1;
      cyc();
      i_mem_read = 1'b1; d_mem_read = 1'b1;
      for (int r = 0; r < 2; r++) begin
         cyc();
         check($sformatf("fp_d_first%0d", r), {f_g_i, f_g_d}, 2'b01);
         l2_ack('0);
         check($sformatf("fp_d_resp%0d", r), {f_i_resp, f_d_resp}, 2'b01);
         d_mem_read = 1'b0;
         cyc(); l2_idle();
         cyc();
         check($sformatf("fp_i_wait%0d", r), f_g_i, 0);
         cyc();
         check($sformatf("fp_i_grant%0d", r), {f_g_i, f_g_d}, 2'b10);
         l2_ack('0);
         check($sformatf("fp_i_resp%0d", r), f_i_resp, 1);
         i_mem_read = 1'b0;
         cyc(); l2_idle();
         i_mem_read = 1'b1; d_mem_read = 1'b1;
         cyc();
      end
      i_mem_read = 1'b0; d_mem_read = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
